// File: rtl/led_pwm_driver.sv
// led_pwm_driver: registers the PIO LED pattern, applies PWM brightness and blink gate.
// Ports: clk, reset, led_pattern, Avalon slave (address/chipselect/write_n/writedata/readdata), led_out.
module led_pwm_driver #(
  parameter int BLINK_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         led_pattern,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic [7:0]         led_out
);

  localparam logic [BLINK_W-1:0] BONE = BLINK_W'(1);

  logic [7:0]         pat_q, pat_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic [7:0]         duty_act_q, duty_act_d;
  logic [7:0]         duty_pend_q, duty_pend_d;
  logic               en_q, en_d;
  logic               blink_en_q, blink_en_d;
  logic [BLINK_W-1:0] period_q, period_d;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic               phase_q, phase_d;
  logic [7:0]         led_q, led_d;

  logic wr;
  logic wr_ctrl;
  logic wr_duty;
  logic wr_period;
  logic pwm_on;
  logic gate;
  logic unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr & (address == 2'd0);
  assign wr_duty   = wr & (address == 2'd1);
  assign wr_period = wr & (address == 2'd2);
  assign unused_wd = ^writedata[31:BLINK_W];

  assign pwm_on = (duty_act_q == 8'hFF) | (pwm_cnt_q < duty_act_q);
  assign gate   = pwm_on & (phase_q | ~blink_en_q);

  always_comb begin
    pat_d       = led_pattern;
    pwm_cnt_d   = pwm_cnt_q + 8'd1;
    duty_act_d  = duty_act_q;
    duty_pend_d = duty_pend_q;
    en_d        = en_q;
    blink_en_d  = blink_en_q;
    period_d    = period_q;
    bcnt_d      = bcnt_q;
    phase_d     = phase_q;
    led_d       = en_q ? (pat_q & {8{gate}}) : 8'h00;

    // Duty only changes on a frame boundary; a write in the same
    // cycle lands in duty_pend and is picked up one frame later.
    if (pwm_cnt_q == 8'hFF) begin
      duty_act_d = duty_pend_q;
    end

    if (wr_ctrl) begin
      en_d       = writedata[0];
      blink_en_d = writedata[1];
    end
    if (wr_duty) begin
      duty_pend_d = writedata[7:0];
    end
    if (wr_period) begin
      period_d = writedata[BLINK_W-1:0];
    end

    if (wr_period || period_q == '0) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (bcnt_q == period_q - BONE) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d  = bcnt_q + BONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q       <= 8'h00;
      pwm_cnt_q   <= 8'h00;
      duty_act_q  <= 8'hFF;
      duty_pend_q <= 8'hFF;
      en_q        <= 1'b1;
      blink_en_q  <= 1'b0;
      period_q    <= '0;
      bcnt_q      <= '0;
      phase_q     <= 1'b1;
      led_q       <= 8'h00;
    end else begin
      pat_q       <= pat_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_act_q  <= duty_act_d;
      duty_pend_q <= duty_pend_d;
      en_q        <= en_d;
      blink_en_q  <= blink_en_d;
      period_q    <= period_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  always_comb begin
    readdata = 32'h0;
    unique case (address)
      2'd0: readdata = {30'h0, blink_en_q, en_q};
      2'd1: readdata = {24'h0, duty_pend_q};
      2'd2: readdata[BLINK_W-1:0] = period_q;
      2'd3: readdata = {15'h0, duty_act_q, phase_q, led_q};
    endcase
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: random + directed stimulus against a frame/elapsed-time model.
// A scoreboard queue carries expected led_out per edge; a negedge monitor checks it.
module tb_led_pwm_driver;

  logic        clk;
  logic        reset;
  logic [7:0]  led_pattern;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led_out;

  int checks = 0;
  int errors = 0;

  led_pwm_driver #(.BLINK_W(24)) dut (
    .clk         (clk),
    .reset       (reset),
    .led_pattern (led_pattern),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .led_out     (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time since reset and since last PERIOD write.
  int          t = 0;
  int          k = 0;
  logic        started = 1'b0;
  logic [7:0]  pat_m = 8'h00;
  logic [7:0]  led_m = 8'h00;
  logic        en_m = 1'b1;
  logic        blink_m = 1'b0;
  logic [7:0]  duty_pend_m = 8'hFF;
  logic [7:0]  duty_act_m = 8'hFF;
  logic [23:0] period_m = 24'h0;
  logic [7:0]  exp_q[$];

  function automatic logic ph(input int kk, input logic [23:0] p);
    if (p == 24'h0) return 1'b1;
    return ((kk / int'(p)) % 2) == 0;
  endfunction

  function automatic logic [31:0] rd_exp(input logic [1:0] a);
    case (a)
      2'd0: return {30'h0, blink_m, en_m};
      2'd1: return {24'h0, duty_pend_m};
      2'd2: return {8'h0, period_m};
      default: return {15'h0, duty_act_m, ph(k, period_m), led_m};
    endcase
  endfunction

  always @(posedge clk) begin : mdl
    int         pwm;
    logic       on;
    logic       g;
    logic [7:0] e;
    if (reset) begin
      started     <= 1'b1;
      t           <= 0;
      k           <= 0;
      pat_m       <= 8'h00;
      led_m       <= 8'h00;
      en_m        <= 1'b1;
      blink_m     <= 1'b0;
      duty_pend_m <= 8'hFF;
      duty_act_m  <= 8'hFF;
      period_m    <= 24'h0;
      exp_q.push_back(8'h00);
    end else begin
      pwm = t % 256;
      on  = (duty_act_m == 8'hFF) || (pwm < int'(duty_act_m));
      g   = on && (ph(k, period_m) || !blink_m);
      e   = en_m ? (pat_m & {8{g}}) : 8'h00;
      exp_q.push_back(e);
      led_m <= e;
      pat_m <= led_pattern;
      if (pwm == 255) duty_act_m <= duty_pend_m;
      t <= t + 1;
      k <= k + 1;
      if (chipselect && !write_n) begin
        case (address)
          2'd0: begin
            en_m    <= writedata[0];
            blink_m <= writedata[1];
          end
          2'd1: duty_pend_m <= writedata[7:0];
          2'd2: begin
            period_m <= writedata[23:0];
            k        <= 0;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin : mon
    logic [7:0]  e;
    logic [31:0] r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led_out !== e) begin
        errors++;
        $display("FAIL led_out t=%0d got %h exp %h", t, led_out, e);
      end
    end
    if (started) begin
      r = rd_exp(address);
      checks++;
      if (readdata !== r) begin
        errors++;
        $display("FAIL readdata addr=%0d t=%0d got %h exp %h",
                 address, t, readdata, r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic count_on(input int n, input logic [7:0] v, output int c);
    c = 0;
    repeat (n) begin
      tick();
      if (led_out == v) c++;
    end
  endtask

  task automatic wait_pwm_ff();
    int guard;
    guard = 0;
    while ((t % 256) != 255 && guard < 300) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL wait_pwm_ff timeout got %0d exp 255", t % 256);
    end
  endtask

  initial begin : stim
    int c;
    logic [1:0]  a;
    logic [31:0] d;
    reset       = 1'b1;
    led_pattern = 8'h00;
    address     = 2'd0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = 32'h0;
    repeat (3) tick();

    reset       = 1'b0;
    led_pattern = 8'hA5;
    address     = 2'd3;
    tick();
    tick();
    chk("pass_through", {24'h0, led_out}, 32'hA5);
    chk("status_reset", readdata, 32'h0001_FFA5);

    led_pattern = 8'hFF;
    wr(2'd1, 32'h40);
    repeat (512) tick();
    count_on(256, 8'hFF, c);
    chk("duty_25pct", c, 64);
    wr(2'd1, 32'h00);
    repeat (512) tick();
    count_on(256, 8'hFF, c);
    chk("duty_zero", c, 0);

    wr(2'd1, 32'hFF);
    repeat (512) tick();
    wait_pwm_ff();
    wr(2'd1, 32'h10);
    count_on(256, 8'hFF, c);
    chk("boundary_old_duty", c, 256);
    count_on(256, 8'hFF, c);
    chk("boundary_new_duty", c, 16);

    wr(2'd1, 32'hFF);
    repeat (512) tick();
    led_pattern = 8'h3C;
    wr(2'd2, 32'd5);
    wr(2'd0, 32'd3);
    repeat (3) tick();
    count_on(10, 8'h3C, c);
    chk("blink_half", c, 5);
    wr(2'd2, 32'd0);
    repeat (3) tick();
    count_on(10, 8'h3C, c);
    chk("blink_off_steady", c, 10);

    wr(2'd0, 32'd0);
    tick();
    chk("disable", {24'h0, led_out}, 32'h0);

    wr(2'd0, 32'd3);
    wr(2'd2, 32'd4);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    address = 2'd0;
    #1;
    chk("rst_ctrl", readdata, 32'h1);
    address = 2'd1;
    #1;
    chk("rst_duty", readdata, 32'hFF);
    address = 2'd2;
    #1;
    chk("rst_period", readdata, 32'h0);
    reset = 1'b0;
    tick();
    tick();
    chk("rst_pass_through", {24'h0, led_out}, 32'h3C);

    for (int i = 0; i < 4000; i++) begin
      led_pattern = 8'($urandom);
      address     = 2'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        a = 2'($urandom);
        d = $urandom;
        if (a == 2'd2) begin
          d = 32'($urandom_range(0, 9));
          if ($urandom_range(0, 1) == 1) d = d | 32'hFF00_0000;
        end
        wr(a, d);
      end else begin
        tick();
      end
    end

    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
